// File: rtl/alarm_ctrl_pkg.sv
// Shared FSM encodings and default timing constants for the alarm ring controller.
package alarm_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_RINGING = 2'd2;
  localparam state_t ST_SNOOZE  = 2'd3;

  localparam int SEC_W = 12;
  localparam int SNZ_W = 3;

  localparam int DEF_RING_TIMEOUT_SEC = 60;
  localparam int DEF_SNOOZE_SEC       = 300;
  localparam int DEF_MAX_SNOOZE       = 3;

endpackage

// File: rtl/ring_sec_timer.sv
// Seconds counter for the alarm FSM: clears on request, counts 1 Hz ticks,
// flags expiry when the incremented count would equal the limit.
module ring_sec_timer
  import alarm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [SEC_W-1:0] limit,
  output logic [SEC_W-1:0] count,
  output logic             expire
);

  assign expire = tick && ((count + 12'd1) == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 12'd1;
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze controller. Optional macro ALARM_LED_BLINK_EN makes the
// ringing LED toggle on every 1 Hz tick instead of staying steadily lit.
module alarm_ring_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       match,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       snoozing,
  output logic [1:0] state
);

  logic             match_d;
  logic             match_rise;
  logic [SNZ_W-1:0] snooze_cnt;
  logic             snooze_ok;
  state_t           next_state;
  logic             state_chg;
  logic [SEC_W-1:0] limit;
  logic [SEC_W-1:0] sec_cnt;
  logic             expire;

  assign match_rise = match & ~match_d;
  assign snooze_ok  = snooze_cnt < SNZ_W'(MAX_SNOOZE);
  assign state_chg  = next_state != state;

  always_comb begin
    limit = '0;
    if (state == ST_RINGING) begin
      limit = SEC_W'(RING_TIMEOUT_SEC);
    end else if (state == ST_SNOOZE) begin
      limit = SEC_W'(SNOOZE_SEC);
    end
  end

  ring_sec_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_chg),
    .tick   (tick_1hz),
    .limit  (limit),
    .count  (sec_cnt),
    .expire (expire)
  );

  // Disarm wins over everything, then stop, snooze, timer expiry, match edge.
  always_comb begin
    next_state = state;
    if (state != ST_IDLE && !alarm_en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alarm_en) next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (match_rise) next_state = ST_RINGING;
        end
        ST_RINGING: begin
          if (stop_btn)                    next_state = ST_ARMED;
          else if (snooze_btn && snooze_ok) next_state = ST_SNOOZE;
          else if (expire)                 next_state = ST_ARMED;
        end
        default: begin
          if (stop_btn)    next_state = ST_ARMED;
          else if (expire) next_state = ST_RINGING;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      match_d    <= 1'b0;
      snooze_cnt <= '0;
      buzzer     <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state    <= next_state;
      match_d  <= match;
      buzzer   <= next_state == ST_RINGING;
      snoozing <= next_state == ST_SNOOZE;
      if (next_state == ST_ARMED || next_state == ST_IDLE) begin
        snooze_cnt <= '0;
      end else if (state == ST_RINGING && next_state == ST_SNOOZE) begin
        snooze_cnt <= snooze_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_led <= 1'b0;
    end else begin
`ifdef ALARM_LED_BLINK_EN
      if (next_state != ST_RINGING) begin
        alarm_led <= 1'b0;
      end else if (state != ST_RINGING) begin
        alarm_led <= 1'b1;
      end else if (tick_1hz) begin
        alarm_led <= ~alarm_led;
      end
`else
      alarm_led <= next_state == ST_RINGING;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with a per-cycle behavioural model.
module tb_alarm_ring_ctrl;

  localparam int RING_T = 5;
  localparam int SNZ_T  = 3;
  localparam int MAX_S  = 2;
`ifdef ALARM_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       alarm_en = 1'b0;
  logic       match = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer;
  logic       alarm_led;
  logic       snoozing;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  alarm_ring_ctrl #(
    .RING_TIMEOUT_SEC (RING_T),
    .SNOOZE_SEC       (SNZ_T),
    .MAX_SNOOZE       (MAX_S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .alarm_en   (alarm_en),
    .match      (match),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzzer     (buzzer),
    .alarm_led  (alarm_led),
    .snoozing   (snoozing),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing; seconds left counts down.
  int m_mode = 0;
  int m_left = 0;
  int m_used = 0;
  bit m_prev = 1'b0;
  bit m_led  = 1'b0;
  bit m_rise;
  bit m_out;
  int m_next;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_left = 0; m_used = 0; m_prev = 1'b0; m_led = 1'b0;
    end else begin
      m_rise = match && !m_prev;
      m_prev = match;
      m_out  = tick_1hz && (m_left == 1);
      m_next = m_mode;
      if (m_mode != 0 && !alarm_en) m_next = 0;
      else if (m_mode == 0 && alarm_en) m_next = 1;
      else if (m_mode == 1 && m_rise) m_next = 2;
      else if (m_mode == 2) begin
        if (stop_btn) m_next = 1;
        else if (snooze_btn && m_used < MAX_S) m_next = 3;
        else if (m_out) m_next = 1;
      end else if (m_mode == 3) begin
        if (stop_btn) m_next = 1;
        else if (m_out) m_next = 2;
      end
      if (m_next != m_mode) begin
        if (m_next == 2) begin
          m_left = RING_T;
          m_led  = 1'b1;
        end else begin
          m_led = 1'b0;
          if (m_next == 3) begin
            m_left = SNZ_T;
            m_used = m_used + 1;
          end else begin
            m_used = 0;
            m_left = 0;
          end
        end
        m_mode = m_next;
      end else if (tick_1hz) begin
        if (m_left > 0) m_left = m_left - 1;
        if (m_mode == 2 && BLINK) m_led = !m_led;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_state", int'(state), m_mode);
      chk("cyc_buzzer", int'(buzzer), int'(m_mode == 2));
      chk("cyc_snoozing", int'(snoozing), int'(m_mode == 3));
      chk("cyc_led", int'(alarm_led), int'(m_led));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step();
    end
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
  endtask

  task automatic press_stop();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
  endtask

  task automatic new_match();
    match = 1'b0; step();
    match = 1'b1; step();
  endtask

  initial begin
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_led", int'(alarm_led), 0);
    check_en = 1'b1;
    rst = 1'b1;
    step();

    // Arm, ring on match edge, auto-stop after five ticks
    alarm_en = 1'b1; step();
    chk("arm_state", int'(state), 1);
    match = 1'b1; step();
    chk("ring_state", int'(state), 2);
    chk("ring_buzzer", int'(buzzer), 1);
    chk("ring_led0", int'(alarm_led), 1);
    do_ticks(1);
    chk("ring_led1", int'(alarm_led), BLINK ? 0 : 1);
    do_ticks(1);
    chk("ring_led2", int'(alarm_led), 1);
    do_ticks(2);
    chk("ring_4tick", int'(state), 2);
    do_ticks(1);
    chk("timeout_state", int'(state), 1);
    chk("timeout_buzzer", int'(buzzer), 0);
    step(2);

    // Two snoozes allowed, third ignored
    new_match();
    chk("ring2_state", int'(state), 2);
    press_snooze(); step();
    chk("snz1_state", int'(state), 3);
    chk("snz1_flag", int'(snoozing), 1);
    do_ticks(2);
    chk("snz1_wait", int'(state), 3);
    do_ticks(1);
    chk("snz1_rering", int'(state), 2);
    press_snooze(); step();
    chk("snz2_state", int'(state), 3);
    do_ticks(3);
    chk("snz2_rering", int'(state), 2);
    press_snooze(); step();
    chk("snz3_ignored", int'(state), 2);

    // Stop with match still high: no re-ring until a fresh edge
    press_stop(); step();
    chk("stop_state", int'(state), 1);
    do_ticks(2); step(2);
    chk("no_rering", int'(state), 1);
    new_match();
    chk("edge_rering", int'(state), 2);

    // Stop and snooze together; disarm with stop
    stop_btn = 1'b1; snooze_btn = 1'b1; step();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("stop_snz_state", int'(state), 1);
    new_match();
    alarm_en = 1'b0; stop_btn = 1'b1; step();
    stop_btn = 1'b0;
    chk("disarm_state", int'(state), 0);

    // Async reset mid-snooze
    alarm_en = 1'b1; step();
    new_match();
    press_snooze(); step();
    do_ticks(1);
    chk("pre_rst_snz", int'(state), 3);
    #2 rst = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_snoozing", int'(snoozing), 0);
    chk("async_buzzer", int'(buzzer), 0);
    chk("async_led", int'(alarm_led), 0);
    @(negedge clk);
    rst = 1'b1; step();
    chk("rel_state", int'(state), 1);
    chk("rel_buzzer", int'(buzzer), 0);
    do_ticks(1); step(2);
    chk("rel_no_ring", int'(state), 1);

    // Stop from snooze, disarm from snooze
    new_match();
    press_snooze(); step();
    press_stop(); step();
    chk("snz_stop", int'(state), 1);
    new_match();
    press_snooze(); step();
    alarm_en = 1'b0; step();
    chk("snz_disarm", int'(state), 0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
